// File: rtl/ddr4_cmd_timing_checker.sv
// DDR4 command legality checker: per-bank/per-group/global countdown timers decide
// whether the scheduler's presented command may issue this cycle (1 rank, 4 BG x 4 banks).
module ddr4_cmd_timing_checker #(
    parameter int T_RP    = 24,
    parameter int T_RCD   = 24,
    parameter int T_RAS   = 52,
    parameter int T_RC    = 76,
    parameter int T_RTP   = 12,
    parameter int T_CWD   = 20,
    parameter int T_WR    = 20,
    parameter int T_BURST = 4,
    parameter int T_RRD_L = 6,
    parameter int T_RRD_S = 4,
    parameter int T_CCD_L = 8,
    parameter int T_CCD_S = 4,
    parameter int T_WTR_L = 12,
    parameter int T_WTR_S = 4,
    parameter int CNT_W   = 7,
    parameter int ROW_W   = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_type,
    input  logic [1:0]       cmd_bg,
    input  logic [1:0]       cmd_ba,
    input  logic [ROW_W-1:0] cmd_row,
    output logic             cmd_ready,
    output logic [15:0]      bank_open,
    output logic [15:0]      viol_cnt
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    localparam cnt_t LD_RP     = cnt_t'(T_RP - 1);
    localparam cnt_t LD_RCD    = cnt_t'(T_RCD - 1);
    localparam cnt_t LD_RAS    = cnt_t'(T_RAS - 1);
    localparam cnt_t LD_RC     = cnt_t'(T_RC - 1);
    localparam cnt_t LD_RTP    = cnt_t'(T_RTP - 1);
    localparam cnt_t LD_RRD_L  = cnt_t'(T_RRD_L - 1);
    localparam cnt_t LD_RRD_S  = cnt_t'(T_RRD_S - 1);
    localparam cnt_t LD_CCD_L  = cnt_t'(T_CCD_L - 1);
    localparam cnt_t LD_CCD_S  = cnt_t'(T_CCD_S - 1);
    localparam cnt_t LD_WTR_L  = cnt_t'(T_CWD + T_BURST + T_WTR_L - 1);
    localparam cnt_t LD_WTR_S  = cnt_t'(T_CWD + T_BURST + T_WTR_S - 1);
    localparam cnt_t LD_WR_PRE = cnt_t'(T_CWD + T_BURST + T_WR - 1);

    cnt_t rcd_q[16];
    cnt_t ras_q[16];
    cnt_t rp_q[16];
    cnt_t rc_q[16];
    cnt_t pre_gate_q[16];
    cnt_t rrd_l_q[4];
    cnt_t ccd_l_q[4];
    cnt_t wtr_l_q[4];
    cnt_t rrd_s_q;
    cnt_t ccd_s_q;
    cnt_t wtr_s_q;
    logic [ROW_W-1:0] open_row_q[16];
    logic [15:0] open_q;
    logic [15:0] viol_q;

    logic [3:0] idx;
    logic       is_open;
    logic       row_hit;
    logic       ready_c;
    logic       issue;

    function automatic cnt_t load_max(input cnt_t cur, input cnt_t ld);
        return (cur > ld) ? cur : ld;
    endfunction

    function automatic cnt_t dec(input cnt_t c);
        return (c == '0) ? '0 : c - cnt_t'(1);
    endfunction

    assign idx     = {cmd_bg, cmd_ba};
    assign is_open = open_q[idx];
    assign row_hit = (open_row_q[idx] == cmd_row);

    // Handshake: a command issues on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on registered state and the presented command.
    always_comb begin
        ready_c = 1'b1;
        if (cmd_valid) begin
            case (cmd_type)
                CMD_NOP: ready_c = 1'b1;
                CMD_ACT: ready_c = !is_open && (rp_q[idx] == '0) && (rc_q[idx] == '0)
                                   && (rrd_s_q == '0) && (rrd_l_q[cmd_bg] == '0);
                CMD_RD:  ready_c = is_open && row_hit && (rcd_q[idx] == '0)
                                   && (ccd_s_q == '0) && (ccd_l_q[cmd_bg] == '0)
                                   && (wtr_s_q == '0) && (wtr_l_q[cmd_bg] == '0);
                CMD_WR:  ready_c = is_open && row_hit && (rcd_q[idx] == '0)
                                   && (ccd_s_q == '0) && (ccd_l_q[cmd_bg] == '0);
                CMD_PRE: ready_c = !is_open || ((ras_q[idx] == '0) && (pre_gate_q[idx] == '0));
                default: ready_c = 1'b0;
            endcase
        end
    end

    assign cmd_ready = ready_c;
    assign issue     = cmd_valid && ready_c;
    assign bank_open = open_q;
    assign viol_cnt  = viol_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 16; b++) begin
                rcd_q[b]      <= '0;
                ras_q[b]      <= '0;
                rp_q[b]       <= '0;
                rc_q[b]       <= '0;
                pre_gate_q[b] <= '0;
                open_row_q[b] <= '0;
            end
            for (int g = 0; g < 4; g++) begin
                rrd_l_q[g] <= '0;
                ccd_l_q[g] <= '0;
                wtr_l_q[g] <= '0;
            end
            rrd_s_q <= '0;
            ccd_s_q <= '0;
            wtr_s_q <= '0;
            open_q  <= '0;
            viol_q  <= '0;
        end else begin
            // Every counter counts down by default; the issuing command overrides below.
            for (int b = 0; b < 16; b++) begin
                rcd_q[b]      <= dec(rcd_q[b]);
                ras_q[b]      <= dec(ras_q[b]);
                rp_q[b]       <= dec(rp_q[b]);
                rc_q[b]       <= dec(rc_q[b]);
                pre_gate_q[b] <= dec(pre_gate_q[b]);
            end
            for (int g = 0; g < 4; g++) begin
                rrd_l_q[g] <= dec(rrd_l_q[g]);
                ccd_l_q[g] <= dec(ccd_l_q[g]);
                wtr_l_q[g] <= dec(wtr_l_q[g]);
            end
            rrd_s_q <= dec(rrd_s_q);
            ccd_s_q <= dec(ccd_s_q);
            wtr_s_q <= dec(wtr_s_q);

            if (issue) begin
                case (cmd_type)
                    CMD_ACT: begin
                        open_q[idx]     <= 1'b1;
                        open_row_q[idx] <= cmd_row;
                        rcd_q[idx]      <= load_max(rcd_q[idx], LD_RCD);
                        ras_q[idx]      <= load_max(ras_q[idx], LD_RAS);
                        rc_q[idx]       <= load_max(rc_q[idx], LD_RC);
                        rrd_s_q         <= load_max(rrd_s_q, LD_RRD_S);
                        rrd_l_q[cmd_bg] <= load_max(rrd_l_q[cmd_bg], LD_RRD_L);
                    end
                    CMD_RD: begin
                        ccd_s_q         <= load_max(ccd_s_q, LD_CCD_S);
                        ccd_l_q[cmd_bg] <= load_max(ccd_l_q[cmd_bg], LD_CCD_L);
                        pre_gate_q[idx] <= load_max(pre_gate_q[idx], LD_RTP);
                    end
                    CMD_WR: begin
                        ccd_s_q         <= load_max(ccd_s_q, LD_CCD_S);
                        ccd_l_q[cmd_bg] <= load_max(ccd_l_q[cmd_bg], LD_CCD_L);
                        wtr_s_q         <= load_max(wtr_s_q, LD_WTR_S);
                        wtr_l_q[cmd_bg] <= load_max(wtr_l_q[cmd_bg], LD_WTR_L);
                        pre_gate_q[idx] <= load_max(pre_gate_q[idx], LD_WR_PRE);
                    end
                    CMD_PRE: begin
                        if (is_open) begin
                            open_q[idx] <= 1'b0;
                            rp_q[idx]   <= load_max(rp_q[idx], LD_RP);
                        end
                    end
                    default: ;
                endcase
            end

            if (cmd_valid && !ready_c && (viol_q != 16'hFFFF))
                viol_q <= viol_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_timing_checker.sv
// Bench for ddr4_cmd_timing_checker: directed timing scenarios plus randomized traffic
// checked against a timestamp-based model of the DDR4 timing rules.
module tb_ddr4_cmd_timing_checker;

    localparam int T_RP = 24, T_RCD = 24, T_RAS = 52, T_RC = 76, T_RTP = 12;
    localparam int T_CWD = 20, T_WR = 20, T_BURST = 4;
    localparam int T_RRD_L = 6, T_RRD_S = 4, T_CCD_L = 8, T_CCD_S = 4;
    localparam int T_WTR_L = 12, T_WTR_S = 4;
    localparam int ROW_W = 17;
    localparam int NEVER = -1000;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic [2:0]       cmd_type;
    logic [1:0]       cmd_bg;
    logic [1:0]       cmd_ba;
    logic [ROW_W-1:0] cmd_row;
    logic             cmd_ready;
    logic [15:0]      bank_open;
    logic [15:0]      viol_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    ddr4_cmd_timing_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_ready (cmd_ready),
        .bank_open (bank_open),
        .viol_cnt  (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: absolute issue times of past commands, legality from plain arithmetic.
    int               cyc;
    logic [15:0]      m_open;
    logic [ROW_W-1:0] m_row[16];
    int               m_act_t[16], m_pre_t[16], m_rd_b[16], m_wr_b[16];
    int               m_act_grp[4], m_col_grp[4], m_wr_grp[4];
    int               m_act_any, m_col_any, m_wr_any;
    logic [15:0]      m_viol;

    task automatic model_reset();
        cyc = 0;
        m_open = '0;
        m_viol = '0;
        for (int b = 0; b < 16; b++) begin
            m_row[b] = '0;
            m_act_t[b] = NEVER; m_pre_t[b] = NEVER; m_rd_b[b] = NEVER; m_wr_b[b] = NEVER;
        end
        for (int g = 0; g < 4; g++) begin
            m_act_grp[g] = NEVER; m_col_grp[g] = NEVER; m_wr_grp[g] = NEVER;
        end
        m_act_any = NEVER; m_col_any = NEVER; m_wr_any = NEVER;
    endtask

    function automatic logic model_ready(input logic v, input logic [2:0] t, input logic [1:0] bg,
                                         input logic [1:0] ba, input logic [ROW_W-1:0] row);
        int b;
        int g;
        b = {28'd0, bg, ba};
        g = {30'd0, bg};
        if (!v) return 1'b1;
        case (t)
            3'd0: return 1'b1;
            3'd1: return !m_open[b] && cyc >= m_pre_t[b] + T_RP && cyc >= m_act_t[b] + T_RC
                         && cyc >= m_act_any + T_RRD_S && cyc >= m_act_grp[g] + T_RRD_L;
            3'd2: return m_open[b] && m_row[b] == row && cyc >= m_act_t[b] + T_RCD
                         && cyc >= m_col_any + T_CCD_S && cyc >= m_col_grp[g] + T_CCD_L
                         && cyc >= m_wr_any + T_CWD + T_BURST + T_WTR_S
                         && cyc >= m_wr_grp[g] + T_CWD + T_BURST + T_WTR_L;
            3'd3: return m_open[b] && m_row[b] == row && cyc >= m_act_t[b] + T_RCD
                         && cyc >= m_col_any + T_CCD_S && cyc >= m_col_grp[g] + T_CCD_L;
            3'd4: return !m_open[b] || (cyc >= m_act_t[b] + T_RAS && cyc >= m_rd_b[b] + T_RTP
                         && cyc >= m_wr_b[b] + T_CWD + T_BURST + T_WR);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update(input logic v, input logic [2:0] t, input logic [1:0] bg,
                                input logic [1:0] ba, input logic [ROW_W-1:0] row, input logic ok);
        int b;
        int g;
        b = {28'd0, bg, ba};
        g = {30'd0, bg};
        if (v && !ok && m_viol != 16'hFFFF) m_viol = m_viol + 16'd1;
        if (v && ok) begin
            case (t)
                3'd1: begin
                    m_open[b] = 1'b1; m_row[b] = row;
                    m_act_t[b] = cyc; m_act_any = cyc; m_act_grp[g] = cyc;
                end
                3'd2: begin
                    m_col_any = cyc; m_col_grp[g] = cyc; m_rd_b[b] = cyc;
                end
                3'd3: begin
                    m_col_any = cyc; m_col_grp[g] = cyc; m_wr_b[b] = cyc;
                    m_wr_any = cyc; m_wr_grp[g] = cyc;
                end
                3'd4: begin
                    if (m_open[b]) begin
                        m_open[b] = 1'b0; m_pre_t[b] = cyc;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Driver: present one command for one cycle; got = DUT ready, exp = model ready.
    task automatic do_cycle(input logic v, input logic [2:0] t, input logic [1:0] bg,
                            input logic [1:0] ba, input logic [ROW_W-1:0] row,
                            output logic got, output logic exp);
        cmd_valid = v; cmd_type = t; cmd_bg = bg; cmd_ba = ba; cmd_row = row;
        exp = model_ready(v, t, bg, ba, row);
        @(negedge clk);
        got = cmd_ready;
        @(posedge clk);
        #1;
        model_update(v, t, bg, ba, row, exp);
        cyc++;
    endtask

    task automatic idle_until(input int target);
        logic g, e;
        while (cyc < target) do_cycle(1'b0, 3'd0, 2'd0, 2'd0, '0, g, e);
    endtask

    task automatic apply_reset();
        cmd_valid = 1'b0; cmd_type = 3'd0; cmd_bg = 2'd0; cmd_ba = 2'd0; cmd_row = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic g, e;
        apply_reset();
        tests_run++;
        if (bank_open !== 16'h0000 || viol_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_state: bank_open=%h viol_cnt=%h expected 0/0", bank_open, viol_cnt);
        end
        do_cycle(1'b1, 3'd0, 2'd0, 2'd0, '0, g, e);
        tests_run++;
        if (g !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_nop_ready: got %b expected 1", g);
        end
    endtask

    task automatic test_act_rd_pre();
        logic g, e;
        logic [16:0] r5;
        r5 = 17'd5;
        apply_reset();
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, r5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL act_first: got %b expected 1", g); end
        idle_until(23);
        do_cycle(1'b1, 3'd2, 2'd0, 2'd0, r5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL trcd_early_23: got %b expected 0", g); end
        do_cycle(1'b1, 3'd2, 2'd0, 2'd0, r5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL trcd_ok_24: got %b expected 1", g); end
        idle_until(51);
        do_cycle(1'b1, 3'd4, 2'd0, 2'd0, r5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL tras_early_51: got %b expected 0", g); end
        do_cycle(1'b1, 3'd4, 2'd0, 2'd0, r5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL tras_ok_52: got %b expected 1", g); end
        idle_until(75);
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, r5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL trc_early_75: got %b expected 0", g); end
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, r5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL trc_ok_76: got %b expected 1", g); end
        tests_run++;
        if (viol_cnt !== 16'd3 || bank_open !== 16'h0001) begin
            tests_failed++;
            $display("FAIL act_rd_pre_counts: viol=%0d open=%h expected 3/0001", viol_cnt, bank_open);
        end
    endtask

    task automatic test_rrd();
        logic g, e;
        apply_reset();
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, 17'd1, g, e);
        idle_until(3);
        do_cycle(1'b1, 3'd1, 2'd1, 2'd0, 17'd1, g, e);
        tests_run++;
        if (g !== 1'b0 || viol_cnt !== 16'd1) begin
            tests_failed++; $display("FAIL rrd_s_early_3: ready=%b viol=%0d expected 0/1", g, viol_cnt);
        end
        do_cycle(1'b1, 3'd1, 2'd1, 2'd0, 17'd1, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL rrd_s_ok_4: got %b expected 1", g); end

        apply_reset();
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, 17'd1, g, e);
        idle_until(4);
        for (int k = 0; k < 2; k++) begin
            do_cycle(1'b1, 3'd1, 2'd0, 2'd1, 17'd1, g, e);
            tests_run++;
            if (g !== 1'b0 || viol_cnt !== 16'(k + 1)) begin
                tests_failed++;
                $display("FAIL rrd_l_early_%0d: ready=%b viol=%0d expected 0/%0d", 4 + k, g, viol_cnt, k + 1);
            end
        end
        do_cycle(1'b1, 3'd1, 2'd0, 2'd1, 17'd1, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL rrd_l_ok_6: got %b expected 1", g); end
    endtask

    task automatic test_ccd_wtr();
        logic g, e;
        apply_reset();
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, 17'd5, g, e);
        idle_until(4);
        do_cycle(1'b1, 3'd1, 2'd1, 2'd0, 17'd5, g, e);
        idle_until(8);
        do_cycle(1'b1, 3'd1, 2'd0, 2'd1, 17'd5, g, e);
        tests_run++;
        if (bank_open !== 16'h0013) begin
            tests_failed++; $display("FAIL ccd_setup_open: got %h expected 0013", bank_open);
        end
        idle_until(40);
        do_cycle(1'b1, 3'd2, 2'd0, 2'd0, 17'd5, g, e);
        idle_until(43);
        do_cycle(1'b1, 3'd2, 2'd1, 2'd0, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL ccd_s_early: got %b expected 0", g); end
        do_cycle(1'b1, 3'd2, 2'd1, 2'd0, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL ccd_s_ok_t4: got %b expected 1", g); end
        idle_until(47);
        do_cycle(1'b1, 3'd2, 2'd0, 2'd1, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL ccd_l_early: got %b expected 0", g); end
        do_cycle(1'b1, 3'd2, 2'd0, 2'd1, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL ccd_l_ok_t8: got %b expected 1", g); end
        idle_until(60);
        do_cycle(1'b1, 3'd3, 2'd0, 2'd0, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL wr_issue: got %b expected 1", g); end
        idle_until(87);
        do_cycle(1'b1, 3'd2, 2'd1, 2'd0, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL wtr_s_early_w27: got %b expected 0", g); end
        do_cycle(1'b1, 3'd2, 2'd1, 2'd0, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL wtr_s_ok_w28: got %b expected 1", g); end
        idle_until(95);
        do_cycle(1'b1, 3'd2, 2'd0, 2'd1, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL wtr_l_early_w35: got %b expected 0", g); end
        do_cycle(1'b1, 3'd2, 2'd0, 2'd1, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL wtr_l_ok_w36: got %b expected 1", g); end
        idle_until(103);
        do_cycle(1'b1, 3'd4, 2'd0, 2'd0, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL twr_early_w43: got %b expected 0", g); end
        do_cycle(1'b1, 3'd4, 2'd0, 2'd0, 17'd5, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL twr_ok_w44: got %b expected 1", g); end
    endtask

    task automatic test_row_miss();
        logic g, e;
        int bad;
        apply_reset();
        do_cycle(1'b1, 3'd1, 2'd2, 2'd3, 17'd5, g, e);
        idle_until(24);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, 3'd2, 2'd2, 2'd3, 17'd6, g, e);
            if (g !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0 || viol_cnt !== 16'd10) begin
            tests_failed++; $display("FAIL row_miss_blocked: ready_hits=%0d viol=%0d expected 0/10", bad, viol_cnt);
        end
        idle_until(52);
        do_cycle(1'b1, 3'd4, 2'd2, 2'd3, 17'd6, g, e);
        idle_until(76);
        do_cycle(1'b1, 3'd1, 2'd2, 2'd3, 17'd6, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL row_miss_reopen: got %b expected 1", g); end
        idle_until(99);
        do_cycle(1'b1, 3'd2, 2'd2, 2'd3, 17'd6, g, e);
        tests_run++;
        if (g !== 1'b0) begin tests_failed++; $display("FAIL row6_rd_early: got %b expected 0", g); end
        do_cycle(1'b1, 3'd2, 2'd2, 2'd3, 17'd6, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL row6_rd_ok: got %b expected 1", g); end
    endtask

    task automatic test_illegal();
        logic g, e;
        apply_reset();
        for (int t = 5; t < 8; t++) begin
            do_cycle(1'b1, 3'(t), 2'd0, 2'd0, '0, g, e);
            tests_run++;
            if (g !== 1'b0 || viol_cnt !== 16'(t - 4)) begin
                tests_failed++;
                $display("FAIL illegal_type_%0d: ready=%b viol=%0d expected 0/%0d", t, g, viol_cnt, t - 4);
            end
        end
        do_cycle(1'b1, 3'd4, 2'd3, 2'd3, '0, g, e);
        tests_run++;
        if (g !== 1'b1 || bank_open !== 16'h0000) begin
            tests_failed++; $display("FAIL pre_closed: ready=%b open=%h expected 1/0000", g, bank_open);
        end
    endtask

    task automatic test_reset_mid();
        logic g, e;
        apply_reset();
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, 17'd3, g, e);
        idle_until(4);
        do_cycle(1'b1, 3'd1, 2'd1, 2'd0, 17'd3, g, e);
        idle_until(8);
        do_cycle(1'b1, 3'd1, 2'd2, 2'd0, 17'd3, g, e);
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, 17'd3, g, e);
        tests_run++;
        if (bank_open !== 16'h0111 || viol_cnt !== 16'd1) begin
            tests_failed++; $display("FAIL mid_setup: open=%h viol=%0d expected 0111/1", bank_open, viol_cnt);
        end
        apply_reset();
        tests_run++;
        if (bank_open !== 16'h0000 || viol_cnt !== 16'h0000) begin
            tests_failed++; $display("FAIL mid_reset_state: open=%h viol=%0d expected 0000/0", bank_open, viol_cnt);
        end
        do_cycle(1'b1, 3'd1, 2'd0, 2'd0, 17'd9, g, e);
        tests_run++;
        if (g !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_act: got %b expected 1", g); end
    endtask

    task automatic test_random();
        logic g, e;
        logic [2:0] t;
        int r;
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 19);
            if (r < 2) t = 3'd0;
            else if (r < 7) t = 3'd1;
            else if (r < 12) t = 3'd2;
            else if (r < 16) t = 3'd3;
            else if (r < 19) t = 3'd4;
            else t = 3'($urandom_range(5, 7));
            do_cycle(1'($urandom_range(0, 9) != 0), t, 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 1)), 17'($urandom_range(5, 6)), g, e);
            tests_run++;
            if (g !== e || bank_open !== m_open || viol_cnt !== m_viol) begin
                tests_failed++;
                $display("FAIL random_cyc%0d: ready=%b open=%h viol=%0d expected %b/%h/%0d",
                         cyc - 1, g, bank_open, viol_cnt, e, m_open, m_viol);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_type = 3'd0; cmd_bg = 2'd0; cmd_ba = 2'd0; cmd_row = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_act_rd_pre();
        test_rrd();
        test_ccd_wtr();
        test_row_miss();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
